// File: rtl/mod_n_sched_pkg.sv
// Shared types and helpers for the mod-N context scheduler.
//   state_t   : scheduler FSM states (IDLE, EXEC)
//   rr_pick   : round-robin winner search starting at a pointer
//   IDXW_MAX  : index width for the largest supported requester count
package mod_n_sched_pkg;

    localparam int unsigned NUM_REQ_MAX = 16;
    localparam int unsigned IDXW_MAX    = $clog2(NUM_REQ_MAX);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Returns the first asserted request at or after ptr, wrapping at nreq.
    // Inputs are zero-extended to the maximum size so one function serves
    // every NUM_REQ; the caller narrows the result to its own index width.
    function automatic logic [IDXW_MAX-1:0] rr_pick(
        input logic [NUM_REQ_MAX-1:0] req,
        input logic [IDXW_MAX-1:0]    ptr,
        input int unsigned            nreq
    );
        logic        found;
        int unsigned i;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ_MAX; k++) begin
            if (k < nreq && !found) begin
                i = ptr + k;
                if (i >= nreq) i = i - nreq;
                if (req[i[IDXW_MAX-1:0]]) begin
                    rr_pick = i[IDXW_MAX-1:0];
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mod_n_inc_unit.sv
// Shared combinational mod-N datapath.
//   ctx      in  : current context value (always 0..N-1)
//   op       in  : 1 = load, 0 = increment
//   load_val in  : value to load; values >= N are stored as 0
//   wrap     out : increment took ctx from N-1 to 0
//                  (present only with MOD_N_SCHED_WRAP_IRQ_EN)
//   next_ctx out : updated context value
module mod_n_inc_unit #(
    parameter int unsigned N     = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] ctx,
    input  logic             op,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] next_ctx
);

    localparam logic [WIDTH-1:0] CTX_MAX = WIDTH'(N - 1);
    // One extra bit so N itself is representable even when N == 2**WIDTH.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(N);

    logic w_at_max;
    assign w_at_max = (ctx == CTX_MAX);

    always_comb begin
        if (op) begin
            next_ctx = ({1'b0, load_val} >= MOD_EXT) ? '0 : load_val;
        end else begin
            next_ctx = w_at_max ? '0 : ctx + WIDTH'(1);
        end
    end

`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    assign wrap = !op && w_at_max;
`endif

endmodule

// File: rtl/mod_n_ctx_scheduler.sv
// Round-robin scheduler sharing one mod-N increment/load datapath between
// NUM_REQ requesters, each owning a private context register held here.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req        : per-requester request, held until granted
//   req_load   : per-requester op select, 1 = load, 0 = increment
//   load_data  : load value for requester i at [i*WIDTH +: WIDTH]
//   gnt        : one-hot grant, 1-cycle pulse
//   busy       : high while an operation is in EXEC
//   done       : 1-cycle pulse, done_id/value_out valid
//   done_id    : index of completed requester
//   value_out  : updated context value
//   wrap_irq   : pulsed with done when an increment wrapped N-1 -> 0
//                (only when MOD_N_SCHED_WRAP_IRQ_EN is defined)
module mod_n_ctx_scheduler
    import mod_n_sched_pkg::*;
#(
    parameter int unsigned N       = 256,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_load,
    input  logic [NUM_REQ*WIDTH-1:0]   load_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    output logic                       wrap_irq,
`endif
    output logic [WIDTH-1:0]           value_out
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);

    state_t              r_state;
    logic [WIDTH-1:0]    r_ctx [NUM_REQ];
    logic [IDXW-1:0]     r_rr_ptr;
    logic [IDXW-1:0]     r_idx;
    logic                r_op;
    logic [WIDTH-1:0]    r_load_val;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_busy;
    logic                r_done;
    logic [IDXW-1:0]     r_done_id;
    logic [WIDTH-1:0]    r_value_out;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    logic                r_wrap_irq;
    logic                w_wrap;
`endif

    logic [IDXW-1:0]     w_pick;
    logic [IDXW-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [WIDTH-1:0]    w_load_arr [NUM_REQ];
    logic [WIDTH-1:0]    w_next_ctx;

    assign w_pick     = IDXW'(rr_pick(NUM_REQ_MAX'(req), IDXW_MAX'(r_rr_ptr), NUM_REQ));
    assign w_next_ptr = (w_pick == IDXW'(NUM_REQ - 1)) ? '0 : w_pick + IDXW'(1);
    assign w_onehot   = NUM_REQ'(1) << w_pick;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_load_arr[i] = load_data[i*WIDTH +: WIDTH];
        end
    end

    // Operands are captured at grant time so the datapath sees stable
    // inputs during EXEC regardless of what the requester does meanwhile.
    mod_n_inc_unit #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_inc (
        .ctx      (r_ctx[r_idx]),
        .op       (r_op),
        .load_val (r_load_val),
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
        .wrap     (w_wrap),
`endif
        .next_ctx (w_next_ctx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_ctx[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_op        <= 1'b0;
            r_load_val  <= '0;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_value_out <= '0;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
            r_wrap_irq  <= 1'b0;
`endif
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
            r_wrap_irq <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_idx      <= w_pick;
                        r_op       <= req_load[w_pick];
                        r_load_val <= w_load_arr[w_pick];
                        r_gnt      <= w_onehot;
                        r_busy     <= 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_ctx[r_idx] <= w_next_ctx;
                    r_done       <= 1'b1;
                    r_done_id    <= r_idx;
                    r_value_out  <= w_next_ctx;
                    r_busy       <= 1'b0;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
                    r_wrap_irq   <= w_wrap;
`endif
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign value_out = r_value_out;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    assign wrap_irq  = r_wrap_irq;
`endif

endmodule

// File: tb/tb_mod_n_ctx_scheduler.sv
// Directed table-driven bench for mod_n_ctx_scheduler (N=4, WIDTH=8, NUM_REQ=4).
module tb_mod_n_ctx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_load;
    logic [31:0] load_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [7:0]  value_out;
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
    logic        wrap_irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mod_n_ctx_scheduler #(
        .N       (4),
        .WIDTH   (8),
        .NUM_REQ (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_load  (req_load),
        .load_data (load_data),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
        .wrap_irq  (wrap_irq),
`endif
        .value_out (value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  ld;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        busy;
        logic        done;
        logic [1:0]  id;
        logic [7:0]  val;
        logic        wrap;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                       input logic [3:0] g, input logic b, input logic dn,
                       input logic [1:0] id, input logic [7:0] v, input logic w);
        tv.push_back('{r, l, d, g, b, dn, id, v, w});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wrap(input string name, input logic exp);
`ifdef MOD_N_SCHED_WRAP_IRQ_EN
        chk(name, 32'(wrap_irq), 32'(exp));
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_load  = '0;
        load_data = '0;
        repeat (2) @(negedge clk);

        chk("rst gnt",       32'(gnt),       32'h0);
        chk("rst busy",      32'(busy),      32'h0);
        chk("rst done",      32'(done),      32'h0);
        chk("rst done_id",   32'(done_id),   32'h0);
        chk("rst value_out", 32'(value_out), 32'h0);
        chk_wrap("rst wrap_irq", 1'b0);

        rst_n = 1'b1;
        tick();
        chk("idle gnt",  32'(gnt),  32'h0);
        chk("idle done", 32'(done), 32'h0);

        //   req      ld       data          gnt     busy  done id  val   wrap
        // single increment on requester 0
        add(4'b0001, 4'b0000, 32'h00000000, 4'b0001, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 0, 8'd1, 0);
        // requester 2 incremented four times, wraps on the last
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd1, 0);
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd2, 0);
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd3, 0);
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd0, 1);
        // rr_ptr=3: lone req 2 still granted; then 0101 grants 0 first
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd1, 0);
        add(4'b0101, 4'b0000, 32'h00000000, 4'b0001, 1, 0, 0, 8'd0, 0);
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 0, 8'd2, 0);
        add(4'b0100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd2, 0);
        // grant requester 3 so rr_ptr returns to 0
        add(4'b1000, 4'b0000, 32'h00000000, 4'b1000, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 3, 8'd1, 0);
        // all four requesting, each dropped on its grant
        add(4'b1111, 4'b0000, 32'h00000000, 4'b0001, 1, 0, 0, 8'd0, 0);
        add(4'b1110, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 0, 8'd3, 0);
        add(4'b1110, 4'b0000, 32'h00000000, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b1100, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd1, 0);
        add(4'b1100, 4'b0000, 32'h00000000, 4'b0100, 1, 0, 0, 8'd0, 0);
        add(4'b1000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 2, 8'd3, 0);
        add(4'b1000, 4'b0000, 32'h00000000, 4'b1000, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 3, 8'd2, 0);
        // loads on requester 1: in-range, out-of-range, N-1, exactly N
        add(4'b0010, 4'b0010, 32'hFFFF02FF, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd2, 0);
        add(4'b0010, 4'b0010, 32'h00000900, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd0, 0);
        add(4'b0010, 4'b1101, 32'h00000300, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd1, 0);
        add(4'b0010, 4'b0010, 32'hFFFF03FF, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd3, 0);
        add(4'b0010, 4'b1101, 32'h00000000, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd0, 1);
        add(4'b0010, 4'b0010, 32'h00000400, 4'b0010, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 0, 1, 1, 8'd0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            req       = tv[i].req;
            req_load  = tv[i].ld;
            load_data = tv[i].data;
            tick();
            chk($sformatf("row%0d gnt", i),  32'(gnt),  32'(tv[i].gnt));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tv[i].done));
            if (tv[i].done) begin
                chk($sformatf("row%0d done_id", i),   32'(done_id),   32'(tv[i].id));
                chk($sformatf("row%0d value_out", i), 32'(value_out), 32'(tv[i].val));
            end
            chk_wrap($sformatf("row%0d wrap_irq", i), tv[i].wrap);
        end

        // reset while EXEC: op discarded, contexts and rr_ptr cleared
        req = 4'b0001; req_load = '0; load_data = '0;
        tick();
        chk("rexec gnt",  32'(gnt),  32'h1);
        chk("rexec busy", 32'(busy), 32'h1);
        req   = '0;
        rst_n = 1'b0;
        #1;
        chk("rexec async gnt",  32'(gnt),  32'h0);
        chk("rexec async busy", 32'(busy), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rexec held done c%0d", c), 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("post-rst done", 32'(done), 32'h0);
        chk("post-rst busy", 32'(busy), 32'h0);
        // rr_ptr back at 0, so 0011 grants requester 0
        req = 4'b0011;
        tick();
        chk("post-rst gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        tick();
        chk("post-rst done0",    32'(done),      32'h1);
        chk("post-rst done_id0", 32'(done_id),   32'h0);
        chk("post-rst value0",   32'(value_out), 32'h1);
        chk_wrap("post-rst wrap0", 1'b0);
        tick();
        chk("post-rst gnt1", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("post-rst done1",    32'(done),      32'h1);
        chk("post-rst done_id1", 32'(done_id),   32'h1);
        chk("post-rst value1",   32'(value_out), 32'h1);
        tick();
        chk("final idle done", 32'(done), 32'h0);
        chk("final idle gnt",  32'(gnt),  32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
